// File: rtl/w25q64_cmd_ctrl.sv
// rtl/w25q64_cmd_ctrl.sv - W25Q64 command sequencer feeding the 49-bit spi_drive frame
// Builds op1/gap/op2/addr/data frames, pulses the driver and polls BUSY after a program.
module w25q64_cmd_ctrl #(
  parameter int POLL_MAX   = 1000,
  parameter int GAP_CYCLES = 4
) (
  input  logic        i_sys_clk,
  input  logic        i_reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [23:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [23:0] rsp_rdata,
  output logic        rsp_err,
  output logic [48:0] tx_data,
  output logic        spi_en,
  input  logic        spi_busy,
  input  logic        spi_done,
  input  logic [48:0] rx_data
);

  localparam int PW = (POLL_MAX > 1) ? $clog2(POLL_MAX + 1) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'((POLL_MAX > 0) ? POLL_MAX - 1 : 0);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_PROG  = 2'd1;
  localparam logic [1:0] OP_JEDEC = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PULSE, S_WAIT_DONE, S_GAP, S_POLL_LOAD, S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic        poll_q, poll_d;
  logic [PW-1:0] poll_cnt_q, poll_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [48:0] tx_q, tx_d;
  logic [23:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic        st_busy;
  logic        poll_last;
  logic        unused_rx;

  assign st_busy   = rx_data[24];
  assign poll_last = (poll_cnt_q == POLL_LAST);
  assign unused_rx = ^rx_data[48:32];

  function automatic logic [48:0] mk_frame(input logic [7:0] op1, input logic [7:0] op2,
                                           input logic [23:0] addr, input logic [7:0] data);
    return {op1, 1'b0, op2, addr, data};
  endfunction

  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= S_IDLE;
      op_q        <= 2'd0;
      poll_q      <= 1'b0;
      poll_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      tx_q        <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      poll_q      <= poll_d;
      poll_cnt_q  <= poll_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      tx_q        <= tx_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (cmd_valid) state_d = S_LOAD;
      S_LOAD:      state_d = (op_q == 2'd3) ? S_RESP : S_PULSE;
      S_PULSE:     if (!spi_busy) state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (spi_done) begin
          if (!poll_q) state_d = (op_q == OP_PROG) ? S_GAP : S_RESP;
          else if (!st_busy || poll_last) state_d = S_RESP;
          else state_d = S_GAP;
        end
      end
      S_GAP:       if (gap_cnt_q == GAP_LAST) state_d = S_POLL_LOAD;
      S_POLL_LOAD: state_d = S_PULSE;
      S_RESP:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    op_d        = op_q;
    poll_d      = poll_q;
    poll_cnt_d  = poll_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    tx_d        = tx_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d       = cmd_op;
          poll_d     = 1'b0;
          poll_cnt_d = '0;
          case (cmd_op)
            OP_READ:  tx_d = mk_frame(8'h04, 8'h03, cmd_addr, 8'h00);
            OP_PROG:  tx_d = mk_frame(8'h06, 8'h02, cmd_addr, cmd_wdata);
            OP_JEDEC: tx_d = mk_frame(8'h04, 8'h9F, 24'h0, 8'h00);
            default:  tx_d = tx_q;
          endcase
        end
      end
      S_LOAD: begin
        if (op_q == 2'd3) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (spi_done) begin
          gap_cnt_d = '0;
          if (!poll_q) begin
            if (op_q == OP_PROG) begin
              poll_d = 1'b1;
            end else begin
              rsp_rdata_d = (op_q == OP_JEDEC) ? rx_data[31:8] : {16'h0, rx_data[7:0]};
              rsp_err_d   = 1'b0;
            end
          end else begin
            // Status byte is reported on both success and timeout.
            rsp_rdata_d = {16'h0, rx_data[31:24]};
            rsp_err_d   = st_busy;
            if (st_busy && !poll_last) poll_cnt_d = poll_cnt_q + 1'b1;
          end
        end
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (gap_cnt_q == GAP_LAST) tx_d = mk_frame(8'h04, 8'h05, 24'h0, 8'h00);
      end
      default: ;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    spi_en    = (state_q == S_PULSE) && !spi_busy;
    rsp_rdata = rsp_rdata_q;
    rsp_err   = rsp_err_q;
    tx_data   = tx_q;
  end

endmodule

// File: tb/tb_w25q64_cmd_ctrl.sv
// tb/tb_w25q64_cmd_ctrl.sv - scoreboard bench for w25q64_cmd_ctrl with driver and flash model
module tb_w25q64_cmd_ctrl;
  localparam int POLL_MAX = 5;
  localparam int GAP      = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [23:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [23:0] rsp_rdata;
  logic [48:0] tx_data, rx_data;
  logic        spi_en, spi_busy, spi_done;

  always #5 clk = ~clk;

  w25q64_cmd_ctrl #(.POLL_MAX(POLL_MAX), .GAP_CYCLES(GAP)) dut (
    .i_sys_clk(clk), .i_reset_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .tx_data(tx_data), .spi_en(spi_en), .spi_busy(spi_busy),
    .spi_done(spi_done), .rx_data(rx_data)
  );

  typedef struct {
    logic [23:0] rdata;
    logic        err;
    bit          chk_data;
  } rsp_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cyc = 0;
  int busy_left = 0;
  bit stuck = 0;
  logic [48:0] exp_frames[$];
  rsp_t        exp_rsp[$];
  logic [7:0]  ref_mem[logic [23:0]];
  logic [7:0]  flash_mem[logic [23:0]];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [48:0] mk(input logic [7:0] o1, input logic [7:0] o2,
                                     input logic [23:0] a, input logic [7:0] d);
    return {o1, 1'b0, o2, a, d};
  endfunction

  function automatic logic [7:0] base_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A ^ {a[3:0], a[7:4]};
  endfunction

  function automatic logic [7:0] ref_byte(input logic [23:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return base_byte(a);
  endfunction

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    if (flash_mem.exists(a)) return flash_mem[a];
    return base_byte(a);
  endfunction

  // Flash behaviour seen through the driver: garbage everywhere except the answered field.
  function automatic logic [48:0] flash_resp(input logic [48:0] f);
    logic [48:0] r;
    r = 49'({$urandom, $urandom});
    case (f[39:32])
      8'h03: r[7:0] = flash_byte(f[31:8]);
      8'h9F: r[31:8] = 24'hEF4017;
      8'h02: if (f[48:40] == {8'h06, 1'b0}) flash_mem[f[31:8]] = f[7:0];
      8'h05: begin
        if (stuck) r[31:24] = 8'h03;
        else if (busy_left > 0) begin
          r[31:24] = 8'h03;
          busy_left--;
        end else r[31:24] = 8'h40;
      end
      default: ;
    endcase
    return r;
  endfunction

  task automatic push_expect(input logic [1:0] op, input logic [23:0] a, input logic [7:0] d,
                             input int nbusy, input bit stk);
    rsp_t e;
    case (op)
      2'd0: begin
        exp_frames.push_back(mk(8'h04, 8'h03, a, 8'h00));
        e = '{{16'h0, ref_byte(a)}, 1'b0, 1'b1};
      end
      2'd1: begin
        exp_frames.push_back(mk(8'h06, 8'h02, a, d));
        for (int i = 0; i < (stk ? POLL_MAX : nbusy + 1); i++)
          exp_frames.push_back(mk(8'h04, 8'h05, 24'h0, 8'h00));
        e = stk ? '{24'h0, 1'b1, 1'b0} : '{24'h000040, 1'b0, 1'b1};
        ref_mem[a] = d;
        busy_left  = nbusy;
        stuck      = stk;
      end
      2'd2: begin
        exp_frames.push_back(mk(8'h04, 8'h9F, 24'h0, 8'h00));
        e = '{24'hEF4017, 1'b0, 1'b1};
      end
      default: e = '{24'h0, 1'b1, 1'b0};
    endcase
    exp_rsp.push_back(e);
  endtask

  task automatic drive(input logic [1:0] op, input logic [23:0] a, input logic [7:0] d);
    int n;
    @(negedge clk);
    cmd_op = op; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [23:0] a, input logic [7:0] d,
                       input int nbusy, input bit stk);
    push_expect(op, a, d, nbusy, stk);
    drive(op, a, d);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_rsp.size() != 0 || !cmd_ready) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 5000) begin
      failures++;
      $display("FAIL %s_timeout pending_rsp=%0d cmd_ready=%0b", name, exp_rsp.size(), cmd_ready);
    end
    check({name, "_frames_left"}, exp_frames.size(), 0);
  endtask

  initial begin : rsp_monitor
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_rsp rdata=%0h err=%0b", rsp_rdata, rsp_err);
        end else begin
          e = exp_rsp.pop_front();
          check("rsp_err", rsp_err, e.err);
          if (e.chk_data) check("rsp_rdata", rsp_rdata, e.rdata);
        end
      end
    end
  end

  initial begin : driver_model
    logic [48:0] f, ef;
    spi_busy = 1'b0; spi_done = 1'b0; rx_data = '0;
    forever begin
      @(negedge clk);
      if (rst_n && spi_en) begin
        f = tx_data;
        check("spi_en_while_busy", spi_busy, 0);
        if (exp_frames.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_frame tx_data=%0h", f);
        end else begin
          ef = exp_frames.pop_front();
          check("tx_frame", f, ef);
          if (ef[39:32] == 8'h05) check("gap_idle_ok", (cyc - done_cyc - 1) >= GAP, 1);
        end
        @(posedge clk);
        #1 spi_busy = 1'b1;
        repeat ($urandom_range(2, 6)) @(posedge clk);
        #1;
        rx_data  = flash_resp(f);
        spi_done = 1'b1;
        spi_busy = 1'b0;
        @(negedge clk);
        done_cyc = cyc;
        @(posedge clk);
        #1 spi_done = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n, accepts;
    logic [1:0] op;
    logic [23:0] a;
    int r;
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = '0; cmd_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_spi_en", spi_en, 0);
    check("rst_tx_data", tx_data, 0);
    @(negedge clk) rst_n = 1'b1;

    ref_mem[24'h000100] = 8'hA5;
    flash_mem[24'h000100] = 8'hA5;
    issue(2'd0, 24'h000100, 8'h00, 0, 0);
    wait_done("read_a5");
    issue(2'd2, 24'hABCDEF, 8'h77, 0, 0);
    wait_done("jedec");
    issue(2'd1, 24'h001234, 8'h3C, 3, 0);
    wait_done("prog_busy3");
    issue(2'd0, 24'h001234, 8'h00, 0, 0);
    wait_done("readback");
    issue(2'd1, 24'h004000, 8'h99, 0, 1);
    wait_done("prog_stuck");
    check("ready_after_timeout", cmd_ready, 1);

    issue(2'd3, 24'h000010, 8'h11, 0, 0);
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("reserved_latency", n, 2);
    wait_done("reserved");

    // cmd_valid held across a whole read: only one accept may happen.
    push_expect(2'd0, 24'h002030, 8'h00, 0, 0);
    @(negedge clk);
    cmd_op = 2'd0; cmd_addr = 24'h002030; cmd_wdata = 8'h00; cmd_valid = 1'b1;
    accepts = 0;
    for (n = 0; n < 5000; n++) begin
      if (cmd_ready) accepts++;
      if (rsp_valid) break;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("held_valid_accepts", accepts, 1);
    wait_done("held_valid");

    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 9);
      op = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      a = 24'h002000 + 24'($urandom_range(0, 7) * 16);
      issue(op, a, 8'($urandom), $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
      wait_done("random_op");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    issue(2'd1, 24'h003000, 8'h5E, 0, 1);
    n = 0;
    while (exp_frames.size() > POLL_MAX - 1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    while (!spi_busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("reach_poll_wait", n < 5000, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_spi_en", spi_en, 0);
    check("midrst_tx_data", tx_data, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    exp_frames.delete();
    exp_rsp.delete();
    stuck = 0;
    busy_left = 0;
    n = 0;
    while ((spi_busy || spi_done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk) rst_n = 1'b1;
    issue(2'd0, 24'h002050, 8'h00, 0, 0);
    wait_done("read_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
